reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Parametrised power-on reset sequencer. It releases NUM_STAGES downstream reset-release lines one after another, at fixed intervals of STAGE_DELAY clocks. It also supports pause (hold) and re-sequence (restart), and provides a done flag. It sits at the top level between the board clock and the subsystems that need staggered start-up: SDRAM controller first, then VGA/LCD timing, then game logic.

Parameters:
CNT_WIDTH, 20, width of the interval counter; requires 1 <= STAGE_DELAY <= 2^CNT_WIDTH.
STAGE_DELAY, 20'hFFFFF, clocks between consecutive stage releases.
NUM_STAGES, 3, number of release outputs, range 1..8.
WDT_LIMIT, 20'hFFFFF, watchdog timeout in clocks; used only with RSTSEQ_WATCHDOG_EN.

Ports:
iCLK  input  1  system clock; all logic on rising edge.
iRST_N  input  1  synchronous active-low reset.
iHOLD  input  1  pause counting while high.
iRESTART  input  1  synchronous re-sequence request (level-sampled).
iKICK  input  1  watchdog kick; used only with RSTSEQ_WATCHDOG_EN.
oRESET  output  NUM_STAGES  bit k = 1 means stage k released (ready); active-high.
oDONE  output  1  all stages released.
oSTAGE  output  4  index of the next stage to release; equals NUM_STAGES once done.
oWDT_TRIP  output  1  one-cycle watchdog trip pulse.

Behaviour:
- Reset, iRST_N sampled low:
  - oRESET=0, oDONE=0, oSTAGE=0, oWDT_TRIP=0.
  - Internal counter cnt=0; state=S_COUNT.
- States:
  - S_COUNT: releasing stages.
  - S_DONE: all stages released.
- Per-edge priority: iRST_N low > iRESTART > iHOLD > normal operation.
- iRESTART=1 on an edge, any state: same effect as reset. Counting resumes on the first edge with iRESTART=0.
- iHOLD=1 in S_COUNT: cnt and oSTAGE frozen; oRESET unchanged. No effect in S_DONE.
- S_COUNT, normal edge:
  - If cnt != STAGE_DELAY-1: cnt <= cnt+1.
  - Else: oRESET[oSTAGE] <= 1, cnt <= 0, oSTAGE <= oSTAGE+1.
  - If that release is the last stage (oSTAGE = NUM_STAGES-1): same edge oDONE <= 1 and state <= S_DONE.
- Release timing: counting from the first non-held edge after reset/restart, bit k rises on edge (k+1)*STAGE_DELAY. The oRESET bits are monotonic: once set, a bit stays 1 until reset or restart.
- Boundary conditions:
  - STAGE_DELAY=1: one stage released per edge.
  - cnt never wraps; comparison is exact at STAGE_DELAY-1 in CNT_WIDTH bits.
  - Reset or restart mid-sequence clears all released bits immediately.
- S_DONE: outputs stable. cnt is reused only by the watchdog; otherwise held at 0.
- oWDT_TRIP = 0 at all times unless the optional feature is enabled.

Optional Feature:
RSTSEQ_WATCHDOG_EN.
- Defined:
  - In S_DONE, cnt increments each edge.
  - iKICK=1 clears cnt to 0 on that edge.
  - If cnt reaches WDT_LIMIT-1 with iKICK=0: the same edge applies restart (all outputs cleared, state=S_COUNT) and oWDT_TRIP=1 for exactly that one cycle.
  - iHOLD does not pause the watchdog.
- Undefined: iKICK ignored, oWDT_TRIP constant 0, cnt held at 0 in S_DONE. Ports remain present in both builds.

Test Plan:
1. CNT_WIDTH=4, STAGE_DELAY=5, NUM_STAGES=3; release iRST_N, hold iHOLD=0 → oRESET goes 001 at edge 5, 011 at edge 10, 111 at edge 15; oDONE=1 at edge 15; oSTAGE=3.
2. Same configuration, iHOLD=1 for edges 3..6 → oRESET[0] delayed to edge 9; oRESET[2] at edge 19.
3. iRESTART pulsed at edge 12 (oRESET=011) → next cycle oRESET=000, oSTAGE=0; oRESET[0] at 5 edges after iRESTART falls.
4. iRST_N low at edge 12, concurrent with iRESTART=1 and iHOLD=1 → all outputs 0, reset takes priority; sequence restarts cleanly.
5. STAGE_DELAY=1, NUM_STAGES=4 → oRESET 0001, 0011, 0111, 1111 on edges 1..4; oDONE at edge 4.
6. RSTSEQ_WATCHDOG_EN, WDT_LIMIT=8, no iKICK after done → 8 edges after oDONE, oWDT_TRIP=1 for one cycle, oRESET=000. With iKICK every 5 cycles → no trip over 100 cycles.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staggered power-on reset release: NUM_STAGES lines go high one by one, STAGE_DELAY clocks apart.
// Define RSTSEQ_WATCHDOG_EN to add a post-sequence watchdog that re-sequences unless iKICK arrives.
module reset_sequencer #(
    parameter int unsigned CNT_WIDTH   = 20,
    parameter int unsigned STAGE_DELAY = 20'hFFFFF,
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned WDT_LIMIT   = 20'hFFFFF
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iHOLD,
    input  logic                  iRESTART,
    input  logic                  iKICK,
    output logic [NUM_STAGES-1:0] oRESET,
    output logic                  oDONE,
    output logic [3:0]            oSTAGE,
    output logic                  oWDT_TRIP
);

    localparam logic [CNT_WIDTH-1:0] STAGE_LAST = CNT_WIDTH'(STAGE_DELAY - 1);
    localparam logic [3:0]           LAST_STAGE = 4'(NUM_STAGES - 1);

    typedef enum logic {
        S_COUNT = 1'b0,
        S_DONE  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [3:0]              stage_q, stage_d;
    logic [NUM_STAGES-1:0]   release_q, release_d;
    logic                    done_q, done_d;
    logic                    trip_q, trip_d;
    logic [NUM_STAGES-1:0]   stage_hit;

    // One-hot decode of the stage about to be released; avoids indexing past NUM_STAGES.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_hit
            assign stage_hit[gi] = (stage_q == 4'(gi));
        end
    endgenerate

`ifdef RSTSEQ_WATCHDOG_EN
    localparam logic [CNT_WIDTH-1:0] WDT_LAST = CNT_WIDTH'(WDT_LIMIT - 1);
`else
    logic unused_kick;
    assign unused_kick = iKICK;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        release_d = release_q;
        done_d    = done_q;
        trip_d    = 1'b0;

        case (state_q)
            S_COUNT: begin
                if (!iHOLD) begin
                    if (cnt_q != STAGE_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        release_d = release_q | stage_hit;
                        cnt_d     = '0;
                        stage_d   = stage_q + 4'd1;
                        if (stage_q == LAST_STAGE) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
`ifdef RSTSEQ_WATCHDOG_EN
                if (iKICK) begin
                    cnt_d = '0;
                end else if (cnt_q == WDT_LAST) begin
                    state_d   = S_COUNT;
                    cnt_d     = '0;
                    stage_d   = 4'd0;
                    release_d = '0;
                    done_d    = 1'b0;
                    trip_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                cnt_d = '0;
`endif
            end
            default: state_d = S_COUNT;
        endcase

        // Restart outranks both hold and the watchdog, and never raises the trip pulse.
        if (iRESTART) begin
            state_d   = S_COUNT;
            cnt_d     = '0;
            stage_d   = 4'd0;
            release_d = '0;
            done_d    = 1'b0;
            trip_d    = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q   <= S_COUNT;
            cnt_q     <= '0;
            stage_q   <= 4'd0;
            release_q <= '0;
            done_q    <= 1'b0;
            trip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            release_q <= release_d;
            done_q    <= done_d;
            trip_q    <= trip_d;
        end
    end

    assign oRESET    = release_q;
    assign oDONE     = done_q;
    assign oSTAGE    = stage_q;
    assign oWDT_TRIP = trip_q;

endmodule
